l2todr_req_throttle: RTL and testbench
======================================

# l2todr_req_throttle

Request-throttling queue between the per-core L2 request arbiter and the directory. It buffers arbitrated `I_l2todr_req_type` requests in a small FIFO. It tracks outstanding requests per source L2, using `nid[4:3]`, and refuses new requests from a source that has reached its limit. Request-ack snacks returning from the directory pass through combinationally toward the arbiter and release that source's credit.

## Interface
Parameters:
- `Depth`, 4: FIFO entries; power of two, 2..16.
- `MaxOut`, 4: max queued plus in-flight requests per source; must be at least 1.

Ports:
- `clk`  in  1  clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `arb_req_valid`  in  1  request from the arbiter.
- `arb_req_retry`  out  1  back-pressure to the arbiter.
- `arb_req`  in  `$bits(I_l2todr_req_type)`  request; `nid[4:3]` is the source L2.
- `l2todr_req_valid`  out  1  request to the directory.
- `l2todr_req_retry`  in  1  back-pressure from the directory.
- `l2todr_req`  out  `$bits(I_l2todr_req_type)`  FIFO head.
- `drtol2_snack_valid`  in  1  snack from the directory.
- `drtol2_snack_retry`  out  1  equals `arb_snack_retry`.
- `drtol2_snack`  in  `$bits(I_drtol2_snack_type)`  snack payload.
- `arb_snack_valid`  out  1  equals `drtol2_snack_valid`.
- `arb_snack_retry`  in  1  back-pressure from the arbiter.
- `arb_snack`  out  `$bits(I_drtol2_snack_type)`  equals `drtol2_snack`.
- `credit_err`  out  1  sticky; set by a request-ack arriving for a source whose count is 0.

## Operation
- Handshake on every channel: a transfer occurs in a cycle where valid=1 and retry=0. Payload is held stable while valid=1 and retry=1.
- Source index `s = arb_req.nid[4:3]`. Each source has a counter `cnt[s]`, `$clog2(MaxOut+1)` bits wide.
- `arb_req_retry = arb_req_valid & (fifo_full | cnt[s] == MaxOut)`. It is 0 when `arb_req_valid` = 0.
- Input transfer: the request is written at the tail, the tail pointer advances, and `cnt[s]` increments.
- `l2todr_req_valid = !fifo_empty`, and `l2todr_req` is the head entry. An output transfer advances the head; counters are unchanged.
- Snack path is purely combinational: valid, retry and data pass straight through with no storage.
- A snack transfer with `snack_is_reqack(drtol2_snack)` true decrements `cnt[drtol2_snack.nid[4:3]]`. Other snacks, such as snoops, leave counters untouched.
- Same source incremented and decremented in the same cycle: the count is unchanged. Different sources: each counter updates independently.
- Decrement when the count is 0: the counter stays 0 and `credit_err` is set until reset.
- Occupancy counter (`$clog2(Depth)+1` bits): full when it equals `Depth`, empty when it is 0. Pointers wrap modulo `Depth`.
- Full FIFO with a pop in the same cycle: input is still retried, because full is computed from registered occupancy. This avoids a comb path from `l2todr_req_retry` to `arb_req_retry`.
- Reset: FIFO emptied, pointers 0, all `cnt` 0, `credit_err` 0. Requests in flight at the directory are forgotten; their later acks produce `credit_err`.

## Timing
- Request latency: an input accepted on edge N is presented as `l2todr_req_valid=1` after edge N, at earliest in the same cycle as the next input. There is no bypass; minimum latency is 1 cycle.
- Throughput: 1 request per cycle while not full and credits are available.
- Snack path: 0 cycles. A credit released at edge N is usable by a request in cycle N+1.
- During and after reset: `l2todr_req_valid`=0 and `credit_err`=0. `arb_req_retry` is 0 in the cycle after reset, even if valid, because occupancy and counts are 0. Snack outputs follow their inputs.
- Order: strict FIFO across all sources; no reordering.

## Structure
- In the shared `scmem` package: `I_l2todr_req_type`, `I_drtol2_snack_type`, and the function `snack_is_reqack()`. Source-field bounds `SC_NID_SRC_HI=4` and `SC_NID_SRC_LO=3` also belong in the package.
- Sub-module `l2todr_req_fifo`: parameterized storage plus pointers plus occupancy, with valid/retry ports. The throttle logic and counters live in the top module.

## Test plan
- Single request `nid=5'b01000`, directory not retrying → `l2todr_req_valid` next cycle with identical payload; `cnt[1]` = 1.
- Five back-to-back source-0 requests with `MaxOut=4` and `Depth=4`, directory held in retry → first 4 accepted and the 5th retried. Release directory retry: the 5th is still retried until a source-0 reqack snack arrives, then accepted the next cycle.
- Fill FIFO with requests from sources 0-3 (one each), then push plus pop simultaneously → push retried, pop completes; push accepted the following cycle.
- Reqack snack for source 2 in the same cycle a source-2 request is accepted → `cnt[2]` unchanged; snack appears on `arb_snack` in the same cycle.
- Reqack snack for source 3 with `cnt[3]`=0 → `credit_err`=1 and held. A non-reqack snoop snack → counters unchanged.
- Assert `reset` with 3 entries queued → next cycle `l2todr_req_valid`=0, `credit_err`=0, counters 0; a new request is accepted immediately.

Source files
------------

// File: rtl/scmem_pkg.sv
// Shared L2/directory message formats and the source-field bounds used to
// attribute requests and request-acks to a source L2.
package scmem;

  localparam int SC_NID_SRC_HI = 4;
  localparam int SC_NID_SRC_LO = 3;
  localparam int SC_NUM_SRC    = 1 << (SC_NID_SRC_HI - SC_NID_SRC_LO + 1);

  typedef enum logic [1:0] {
    SC_SNACK_REQACK = 2'd0,
    SC_SNACK_SNOOP  = 2'd1,
    SC_SNACK_INVAL  = 2'd2,
    SC_SNACK_NACK   = 2'd3
  } snack_kind_t;

  typedef struct packed {
    logic [4:0]  nid;
    logic [5:0]  l2id;
    logic [2:0]  cmd;
    logic [37:0] paddr;
  } I_l2todr_req_type;

  typedef struct packed {
    logic [4:0]  nid;
    logic [5:0]  l2id;
    snack_kind_t kind;
    logic [37:0] paddr;
  } I_drtol2_snack_type;

  function automatic logic snack_is_reqack(input I_drtol2_snack_type snack);
    return snack.kind == SC_SNACK_REQACK;
  endfunction

endpackage

// File: rtl/l2todr_req_fifo.sv
// Power-of-two request FIFO with valid/retry ports; full/empty come from a
// registered occupancy count so in_retry never depends on out_retry.
module l2todr_req_fifo #(
  parameter int Depth = 4,
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_retry,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_retry,
  output logic [Width-1:0] out_data
);

  localparam int AW = $clog2(Depth);
  localparam int OW = AW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             full, empty, push, pop;

  assign full      = (occ_q == OW'(Depth));
  assign empty     = (occ_q == '0);
  assign in_retry  = in_valid & full;
  assign out_valid = ~empty;
  assign out_data  = mem_q[rd_ptr_q];
  assign push      = in_valid & ~full;
  assign pop       = out_valid & ~out_retry;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    occ_d    = occ_q + OW'(push) - OW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: rtl/l2todr_req_throttle.sv
// Per-source credit throttle in front of the directory request FIFO; request-ack
// snacks pass straight through and return the credit of their source.
module l2todr_req_throttle
  import scmem::*;
#(
  parameter int Depth  = 4,
  parameter int MaxOut = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arb_req_valid,
  output logic               arb_req_retry,
  input  I_l2todr_req_type   arb_req,
  output logic               l2todr_req_valid,
  input  logic               l2todr_req_retry,
  output I_l2todr_req_type   l2todr_req,
  input  logic               drtol2_snack_valid,
  output logic               drtol2_snack_retry,
  input  I_drtol2_snack_type drtol2_snack,
  output logic               arb_snack_valid,
  input  logic               arb_snack_retry,
  output I_drtol2_snack_type arb_snack,
  output logic               credit_err
);

  localparam int CW = $clog2(MaxOut + 1);
  localparam int SW = SC_NID_SRC_HI - SC_NID_SRC_LO + 1;

  logic [CW-1:0] cnt_q [SC_NUM_SRC];
  logic [CW-1:0] cnt_d [SC_NUM_SRC];
  logic          credit_err_q, credit_err_d;
  logic [SW-1:0] req_src, snack_src;
  logic          credit_full, fifo_in_valid, fifo_in_retry;
  logic          push, ack;

  assign arb_snack_valid    = drtol2_snack_valid;
  assign drtol2_snack_retry = arb_snack_retry;
  assign arb_snack          = drtol2_snack;

  assign req_src       = arb_req.nid[SC_NID_SRC_HI:SC_NID_SRC_LO];
  assign snack_src     = drtol2_snack.nid[SC_NID_SRC_HI:SC_NID_SRC_LO];
  assign credit_full   = (cnt_q[req_src] == CW'(MaxOut));
  assign fifo_in_valid = arb_req_valid & ~credit_full;
  assign arb_req_retry = (arb_req_valid & credit_full) | fifo_in_retry;
  assign push          = arb_req_valid & ~arb_req_retry;
  assign ack           = drtol2_snack_valid & ~arb_snack_retry & snack_is_reqack(drtol2_snack);
  assign credit_err    = credit_err_q;

  l2todr_req_fifo #(
    .Depth (Depth),
    .Width ($bits(I_l2todr_req_type))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (fifo_in_valid),
    .in_retry  (fifo_in_retry),
    .in_data   (arb_req),
    .out_valid (l2todr_req_valid),
    .out_retry (l2todr_req_retry),
    .out_data  (l2todr_req)
  );

  // A same-cycle grant and ack on one source cancel; an ack at zero saturates.
  always_comb begin
    credit_err_d = credit_err_q;
    for (int i = 0; i < SC_NUM_SRC; i++) begin
      cnt_d[i] = cnt_q[i];
      if (push && req_src == SW'(i) && !(ack && snack_src == SW'(i))) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (ack && snack_src == SW'(i) && !(push && req_src == SW'(i))) begin
        if (cnt_q[i] == '0) credit_err_d = 1'b1;
        else                cnt_d[i] = cnt_q[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credit_err_q <= 1'b0;
      for (int i = 0; i < SC_NUM_SRC; i++) cnt_q[i] <= '0;
    end else begin
      credit_err_q <= credit_err_d;
      for (int i = 0; i < SC_NUM_SRC; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_l2todr_req_throttle.sv
// Directed bench for the request throttle: credits, FIFO order, full/retry,
// snack pass-through, credit errors and reset.
module tb_l2todr_req_throttle;
  import scmem::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               arb_req_valid;
  logic               arb_req_retry;
  I_l2todr_req_type   arb_req;
  logic               l2todr_req_valid;
  logic               l2todr_req_retry;
  I_l2todr_req_type   l2todr_req;
  logic               drtol2_snack_valid;
  logic               drtol2_snack_retry;
  I_drtol2_snack_type drtol2_snack;
  logic               arb_snack_valid;
  logic               arb_snack_retry;
  I_drtol2_snack_type arb_snack;
  logic               credit_err;

  int errors = 0;
  int checks = 0;

  l2todr_req_throttle #(.Depth(4), .MaxOut(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .arb_req_valid      (arb_req_valid),
    .arb_req_retry      (arb_req_retry),
    .arb_req            (arb_req),
    .l2todr_req_valid   (l2todr_req_valid),
    .l2todr_req_retry   (l2todr_req_retry),
    .l2todr_req         (l2todr_req),
    .drtol2_snack_valid (drtol2_snack_valid),
    .drtol2_snack_retry (drtol2_snack_retry),
    .drtol2_snack       (drtol2_snack),
    .arb_snack_valid    (arb_snack_valid),
    .arb_snack_retry    (arb_snack_retry),
    .arb_snack          (arb_snack),
    .credit_err         (credit_err)
  );

  always #5 clk = ~clk;

  function automatic I_l2todr_req_type mkReq(input logic [4:0] nid, input logic [37:0] addr);
    I_l2todr_req_type r;
    r.nid   = nid;
    r.l2id  = 6'h2a;
    r.cmd   = 3'd1;
    r.paddr = addr;
    return r;
  endfunction

  function automatic I_drtol2_snack_type mkSnack(input logic [4:0] nid, input snack_kind_t kind);
    I_drtol2_snack_type s;
    s.nid   = nid;
    s.l2id  = 6'h15;
    s.kind  = kind;
    s.paddr = 38'h3_0000_0000 | 38'(nid);
    return s;
  endfunction

  task automatic applyStimulus(input logic rv, input I_l2todr_req_type r, input logic dr,
                               input logic sv, input I_drtol2_snack_type s, input logic sr);
    arb_req_valid      = rv;
    arb_req            = r;
    l2todr_req_retry   = dr;
    drtol2_snack_valid = sv;
    drtol2_snack       = s;
    arb_snack_retry    = sr;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  I_l2todr_req_type   r, r5, rx, r1, r2, r6, r7, nr;
  I_l2todr_req_type   t2q [4];
  I_l2todr_req_type   t3q [4];
  I_l2todr_req_type   drainq [3];
  I_drtol2_snack_type s, s0, s2, s3, sn, ns;

  initial begin
    nr = mkReq(5'd0, 38'd0);
    ns = mkSnack(5'd0, SC_SNACK_SNOOP);
    reset = 1'b1;
    applyStimulus(1'b0, nr, 1'b0, 1'b0, ns, 1'b0);
    nextCycle();
    nextCycle();

    // Reset state, snack path follows inputs even in reset
    s = mkSnack(5'b01000, SC_SNACK_SNOOP);
    applyStimulus(1'b0, nr, 1'b0, 1'b1, s, 1'b1);
    checkOutput("rst_req_valid", 64'(l2todr_req_valid), 64'd0);
    checkOutput("rst_credit_err", 64'(credit_err), 64'd0);
    checkOutput("rst_snack_valid", 64'(arb_snack_valid), 64'd1);
    checkOutput("rst_snack_retry", 64'(drtol2_snack_retry), 64'd1);
    reset = 1'b0;

    // Single request from source 1
    r = mkReq(5'b01000, 38'h100);
    applyStimulus(1'b1, r, 1'b0, 1'b0, ns, 1'b0);
    checkOutput("t1_retry_after_reset", 64'(arb_req_retry), 64'd0);
    nextCycle();
    applyStimulus(1'b0, nr, 1'b0, 1'b0, ns, 1'b0);
    checkOutput("t1_out_valid", 64'(l2todr_req_valid), 64'd1);
    checkOutput("t1_out_payload", 64'(l2todr_req), 64'(r));
    checkOutput("t1_cnt1", 64'(dut.cnt_q[1]), 64'd1);
    nextCycle();
    checkOutput("t1_popped", 64'(l2todr_req_valid), 64'd0);
    checkOutput("t1_cnt1_inflight", 64'(dut.cnt_q[1]), 64'd1);
    s = mkSnack(5'b01000, SC_SNACK_REQACK);
    applyStimulus(1'b0, nr, 1'b0, 1'b1, s, 1'b0);
    checkOutput("t1_snack_valid", 64'(arb_snack_valid), 64'd1);
    checkOutput("t1_snack_data", 64'(arb_snack), 64'(s));
    checkOutput("t1_snack_retry", 64'(drtol2_snack_retry), 64'd0);
    nextCycle();
    applyStimulus(1'b0, nr, 1'b0, 1'b0, ns, 1'b0);
    checkOutput("t1_cnt1_released", 64'(dut.cnt_q[1]), 64'd0);

    // Source 0 hits its credit limit
    for (int i = 0; i < 4; i++) begin
      t2q[i] = mkReq({2'b00, 3'(i)}, 38'h200 + 38'(i));
      applyStimulus(1'b1, t2q[i], 1'b1, 1'b0, ns, 1'b0);
      checkOutput($sformatf("t2_accept%0d", i), 64'(arb_req_retry), 64'd0);
      nextCycle();
    end
    r5 = mkReq(5'b00111, 38'h204);
    applyStimulus(1'b1, r5, 1'b1, 1'b0, ns, 1'b0);
    checkOutput("t2_cnt0_full", 64'(dut.cnt_q[0]), 64'd4);
    checkOutput("t2_fifth_retry", 64'(arb_req_retry), 64'd1);
    nextCycle();
    applyStimulus(1'b1, r5, 1'b0, 1'b0, ns, 1'b0);
    checkOutput("t2_full_pop_retry", 64'(arb_req_retry), 64'd1);
    checkOutput("t2_head0", 64'(l2todr_req), 64'(t2q[0]));
    nextCycle();
    s0 = mkSnack(5'b00000, SC_SNACK_REQACK);
    applyStimulus(1'b1, r5, 1'b0, 1'b1, s0, 1'b0);
    checkOutput("t2_credit_retry", 64'(arb_req_retry), 64'd1);
    checkOutput("t2_head1", 64'(l2todr_req), 64'(t2q[1]));
    nextCycle();
    applyStimulus(1'b1, r5, 1'b0, 1'b0, ns, 1'b0);
    checkOutput("t2_after_ack_accept", 64'(arb_req_retry), 64'd0);
    checkOutput("t2_cnt0_after_ack", 64'(dut.cnt_q[0]), 64'd3);
    checkOutput("t2_head2", 64'(l2todr_req), 64'(t2q[2]));
    nextCycle();
    applyStimulus(1'b0, nr, 1'b0, 1'b0, ns, 1'b0);
    checkOutput("t2_head3", 64'(l2todr_req), 64'(t2q[3]));
    checkOutput("t2_cnt0_refilled", 64'(dut.cnt_q[0]), 64'd4);
    nextCycle();
    checkOutput("t2_head_fifth", 64'(l2todr_req), 64'(r5));
    nextCycle();
    checkOutput("t2_drained", 64'(l2todr_req_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, nr, 1'b0, 1'b1, s0, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, nr, 1'b0, 1'b0, ns, 1'b0);
    checkOutput("t2_cnt0_cleared", 64'(dut.cnt_q[0]), 64'd0);
    checkOutput("t2_no_err", 64'(credit_err), 64'd0);

    // Full FIFO from four sources, then push and pop together
    for (int i = 0; i < 4; i++) begin
      t3q[i] = mkReq({2'(i), 3'b000}, 38'h300 + 38'(i));
      applyStimulus(1'b1, t3q[i], 1'b1, 1'b0, ns, 1'b0);
      nextCycle();
    end
    rx = mkReq(5'b00001, 38'h310);
    applyStimulus(1'b1, rx, 1'b0, 1'b0, ns, 1'b0);
    checkOutput("t3_full_push_retry", 64'(arb_req_retry), 64'd1);
    checkOutput("t3_pop_valid", 64'(l2todr_req_valid), 64'd1);
    checkOutput("t3_head0", 64'(l2todr_req), 64'(t3q[0]));
    nextCycle();
    applyStimulus(1'b1, rx, 1'b0, 1'b0, ns, 1'b0);
    checkOutput("t3_push_next", 64'(arb_req_retry), 64'd0);
    checkOutput("t3_head1", 64'(l2todr_req), 64'(t3q[1]));
    nextCycle();
    applyStimulus(1'b0, nr, 1'b1, 1'b0, ns, 1'b0);
    checkOutput("t3_cnt0", 64'(dut.cnt_q[0]), 64'd2);
    drainq[0] = t3q[2];
    drainq[1] = t3q[3];
    drainq[2] = rx;
    applyStimulus(1'b0, nr, 1'b0, 1'b0, ns, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t3_drain%0d", i), 64'(l2todr_req), 64'(drainq[i]));
      nextCycle();
    end
    checkOutput("t3_empty", 64'(l2todr_req_valid), 64'd0);

    // Same-source grant and ack cancel; different sources update independently
    r2 = mkReq(5'b10000, 38'h400);
    s2 = mkSnack(5'b10000, SC_SNACK_REQACK);
    applyStimulus(1'b1, r2, 1'b1, 1'b1, s2, 1'b0);
    checkOutput("t4_accept", 64'(arb_req_retry), 64'd0);
    checkOutput("t4_snack_same_cycle", 64'(arb_snack), 64'(s2));
    nextCycle();
    r1 = mkReq(5'b01010, 38'h401);
    s3 = mkSnack(5'b11000, SC_SNACK_REQACK);
    applyStimulus(1'b1, r1, 1'b1, 1'b1, s3, 1'b0);
    checkOutput("t4_cnt2_unchanged", 64'(dut.cnt_q[2]), 64'd1);
    nextCycle();
    applyStimulus(1'b0, nr, 1'b1, 1'b0, ns, 1'b0);
    checkOutput("t4_cnt1_inc", 64'(dut.cnt_q[1]), 64'd2);
    checkOutput("t4_cnt3_dec", 64'(dut.cnt_q[3]), 64'd0);
    checkOutput("t4_no_err", 64'(credit_err), 64'd0);

    // Ack for an idle source, then a snoop and a retried ack
    applyStimulus(1'b0, nr, 1'b1, 1'b1, s3, 1'b0);
    nextCycle();
    applyStimulus(1'b0, nr, 1'b1, 1'b0, ns, 1'b0);
    checkOutput("t5_credit_err", 64'(credit_err), 64'd1);
    checkOutput("t5_cnt3_floor", 64'(dut.cnt_q[3]), 64'd0);
    sn = mkSnack(5'b00000, SC_SNACK_SNOOP);
    applyStimulus(1'b0, nr, 1'b1, 1'b1, sn, 1'b0);
    nextCycle();
    applyStimulus(1'b0, nr, 1'b1, 1'b1, s0, 1'b1);
    checkOutput("t5_snoop_cnt0", 64'(dut.cnt_q[0]), 64'd2);
    checkOutput("t5_err_sticky", 64'(credit_err), 64'd1);
    checkOutput("t5_snack_retry_pass", 64'(drtol2_snack_retry), 64'd1);
    nextCycle();
    applyStimulus(1'b0, nr, 1'b1, 1'b0, ns, 1'b0);
    checkOutput("t5_retried_ack_cnt0", 64'(dut.cnt_q[0]), 64'd2);

    // Reset with three entries queued
    r6 = mkReq(5'b00011, 38'h600);
    applyStimulus(1'b1, r6, 1'b1, 1'b0, ns, 1'b0);
    nextCycle();
    applyStimulus(1'b0, nr, 1'b1, 1'b0, ns, 1'b0);
    checkOutput("t6_head_before_reset", 64'(l2todr_req), 64'(r2));
    reset = 1'b1;
    nextCycle();
    checkOutput("t6_valid_cleared", 64'(l2todr_req_valid), 64'd0);
    checkOutput("t6_err_cleared", 64'(credit_err), 64'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t6_cnt%0d", i), 64'(dut.cnt_q[i]), 64'd0);
    end
    reset = 1'b0;
    r7 = mkReq(5'b11001, 38'h700);
    applyStimulus(1'b1, r7, 1'b0, 1'b0, ns, 1'b0);
    checkOutput("t6_accept_after_reset", 64'(arb_req_retry), 64'd0);
    nextCycle();
    applyStimulus(1'b0, nr, 1'b0, 1'b0, ns, 1'b0);
    checkOutput("t6_out_valid", 64'(l2todr_req_valid), 64'd1);
    checkOutput("t6_out_payload", 64'(l2todr_req), 64'(r7));
    checkOutput("t6_cnt3", 64'(dut.cnt_q[3]), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
